// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_pkg
//  Description : Shared definitions for the HI/LO multiply/divide unit.
//                Operation encoding, FSM state type, default datapath width
//                and a helper that tells real commands from NOP/reserved.
//  Macros      : none (HILO_BYPASS_EN is consumed by hilo_muldiv_unit)
//  Revision    : 1.0  initial release
// ============================================================================
package hilo_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    SIGN = 2'd3
  } state_t;

  // Encoding 7 is reserved and behaves exactly like NOP.
  function automatic logic is_cmd(input logic [2:0] op);
    return (op >= OP_MULT) && (op <= OP_MTLO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/hilo_muldiv_unit_div_core.sv
`default_nettype none
// ============================================================================
//  Module      : div_core
//  Description : Iterative unsigned restoring divider, one quotient bit per
//                step. The caller presents magnitudes; sign handling, step
//                counting and divide-by-zero policy live in the parent.
//  Ports       : clk, rst_n      clock / async active-low reset
//                start           load dividend/divisor (wins over step)
//                dividend        unsigned dividend
//                divisor         unsigned divisor
//                step            perform one restoring iteration
//                quotient        current quotient register
//                remainder       current partial remainder
//  Revision    : 1.0  initial release
// ============================================================================
module div_core
  import hilo_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             step,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvs;

  // The dividend is shifted out of the quotient register MSB-first while
  // quotient bits are shifted in at the bottom.
  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_fits;

  assign w_shift = {r_rem, r_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, r_dvs};
  assign w_fits  = ~w_diff[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_quo <= '0;
      r_rem <= '0;
      r_dvs <= '0;
    end else if (start) begin
      r_quo <= dividend;
      r_rem <= '0;
      r_dvs <= divisor;
    end else if (step) begin
      r_quo <= {r_quo[WIDTH-2:0], w_fits};
      r_rem <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    end
  end

  assign quotient  = r_quo;
  assign remainder = r_rem;

endmodule
`default_nettype wire

// File: rtl/hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_muldiv_unit
//  Description : Multi-cycle producer for the HI/LO registers. Runs
//                MULT/MULTU/DIV/DIVU iteratively, accepts MTHI/MTLO, and
//                asks the pipeline to stall while an op is in flight.
//  Macros      : HILO_BYPASS_EN - hi_out/lo_out show the value being written
//                in the same cycle (MTHI/MTLO accept, final MUL/SIGN cycle).
//  Ports       : clk, rst_n      clock / async active-low reset
//                op_valid, op    command from ID/EX (held until accept)
//                src_a, src_b    forwarded rs / rt operands
//                mf_req          MFHI/MFLO waiting in ID/EX
//                flush           squash the in-flight operation
//                accept          command taken this cycle (comb)
//                busy            mul/div in progress (registered)
//                stall_req       freeze IF/ID/EX (comb)
//                hi_out, lo_out  HI / LO values
//                done            one-cycle pulse after a mul/div write
//  Revision    : 1.0  initial release
// ============================================================================
module hilo_muldiv_unit
  import hilo_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int MUL_CYCLES = 4,
  // The divider retires one quotient bit per cycle, so this must equal WIDTH.
  parameter int DIV_CYCLES = WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mf_req,
  input  logic             flush,
  output logic             accept,
  output logic             busy,
  output logic             stall_req,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             done
);

  localparam int c_cnt_max = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
  localparam logic [c_cnt_w-1:0] c_mul_last = c_cnt_w'(MUL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_div_last = c_cnt_w'(DIV_CYCLES - 1);

  state_t             r_state;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_a;      // raw operands, kept for sign fix-up and /0
  logic [WIDTH-1:0]   r_b;
  logic               r_signed;

  logic               w_accept;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_op_signed;
  logic [WIDTH-1:0]   w_abs_a;
  logic [WIDTH-1:0]   w_abs_b;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_accept    = op_valid & is_cmd(op) & (r_state == IDLE) & ~flush;
  assign w_is_mul    = (op == OP_MULT) | (op == OP_MULTU);
  assign w_is_div    = (op == OP_DIV)  | (op == OP_DIVU);
  assign w_op_signed = (op == OP_MULT) | (op == OP_DIV);

  // Signed divide works on magnitudes; the result sign is restored in SIGN.
  assign w_abs_a = ((op == OP_DIV) && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b = ((op == OP_DIV) && src_b[WIDTH-1]) ? -src_b : src_b;

  div_core #(.WIDTH(WIDTH)) u_div_core (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (w_accept & w_is_div),
    .dividend  (w_abs_a),
    .divisor   (w_abs_b),
    .step      (r_state == DIV),
    .quotient  (w_quo),
    .remainder (w_rem)
  );

  // Full-width product; sign- or zero-extension selects MULT vs MULTU.
  logic [2*WIDTH-1:0] w_ext_a;
  logic [2*WIDTH-1:0] w_ext_b;
  logic [2*WIDTH-1:0] w_prod;

  assign w_ext_a = r_signed ? {{WIDTH{r_a[WIDTH-1]}}, r_a} : {{WIDTH{1'b0}}, r_a};
  assign w_ext_b = r_signed ? {{WIDTH{r_b[WIDTH-1]}}, r_b} : {{WIDTH{1'b0}}, r_b};
  assign w_prod  = w_ext_a * w_ext_b;

  // Quotient sign is the XOR of operand signs; remainder follows the dividend.
  logic             w_neg_q;
  logic             w_neg_r;
  logic             w_dz;
  logic [WIDTH-1:0] w_div_hi;
  logic [WIDTH-1:0] w_div_lo;

  assign w_neg_q  = r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
  assign w_neg_r  = r_signed & r_a[WIDTH-1];
  assign w_dz     = (r_b == '0);
  assign w_div_hi = w_dz ? r_a : (w_neg_r ? -w_rem : w_rem);
  assign w_div_lo = w_dz ? '1  : (w_neg_q ? -w_quo : w_quo);

  // HI/LO write port, shared by the register update and the optional bypass.
  logic             w_mul_wr;
  logic             w_div_wr;
  logic             w_hi_we;
  logic             w_lo_we;
  logic [WIDTH-1:0] w_hi_d;
  logic [WIDTH-1:0] w_lo_d;

  assign w_mul_wr = (r_state == MUL) & (r_cnt == '0) & ~flush;
  assign w_div_wr = (r_state == SIGN) & ~flush;

  always_comb begin
    w_hi_we = 1'b0;
    w_lo_we = 1'b0;
    w_hi_d  = r_hi;
    w_lo_d  = r_lo;
    if (w_mul_wr) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_hi_d  = w_prod[2*WIDTH-1:WIDTH];
      w_lo_d  = w_prod[WIDTH-1:0];
    end else if (w_div_wr) begin
      w_hi_we = 1'b1;
      w_lo_we = 1'b1;
      w_hi_d  = w_div_hi;
      w_lo_d  = w_div_lo;
    end else if (w_accept && (op == OP_MTHI)) begin
      w_hi_we = 1'b1;
      w_hi_d  = src_a;
    end else if (w_accept && (op == OP_MTLO)) begin
      w_lo_we = 1'b1;
      w_lo_d  = src_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
    end else begin
      if (w_hi_we) r_hi <= w_hi_d;
      if (w_lo_we) r_lo <= w_lo_d;
      r_done <= 1'b0;

      if (flush) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept && (w_is_mul || w_is_div)) begin
              r_state  <= w_is_mul ? MUL : DIV;
              r_cnt    <= w_is_mul ? c_mul_last : c_div_last;
              r_busy   <= 1'b1;
              r_a      <= src_a;
              r_b      <= src_b;
              r_signed <= w_op_signed;
            end
          end
          MUL: begin
            if (r_cnt == '0) begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_cnt_w'(1);
            end
          end
          DIV: begin
            if (r_cnt == '0) begin
              r_state <= SIGN;
            end else begin
              r_cnt <= r_cnt - c_cnt_w'(1);
            end
          end
          SIGN: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign accept    = w_accept;
  assign busy      = r_busy;
  assign done      = r_done;
  assign stall_req = r_busy & (mf_req | (op_valid & is_cmd(op)));

`ifdef HILO_BYPASS_EN
  assign hi_out = w_hi_we ? w_hi_d : r_hi;
  assign lo_out = w_lo_we ? w_lo_d : r_lo;
`else
  assign hi_out = r_hi;
  assign lo_out = r_lo;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hilo_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hilo_muldiv_unit
//  Description : Self-checking bench for hilo_muldiv_unit. Directed cases
//                for the named corner conditions followed by random
//                commands, all compared against an arithmetic HI/LO model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_hilo_muldiv_unit;
  import hilo_pkg::*;

  localparam int W     = 32;
  localparam int MUL_C = 4;
  localparam int DIV_C = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          op_valid;
  logic [2:0]    op;
  logic [W-1:0]  src_a;
  logic [W-1:0]  src_b;
  logic          mf_req;
  logic          flush;
  logic          accept;
  logic          busy;
  logic          stall_req;
  logic [W-1:0]  hi_out;
  logic [W-1:0]  lo_out;
  logic          done;

  int n_err = 0;
  int n_chk = 0;

  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  hilo_muldiv_unit #(.WIDTH(W), .MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .mf_req    (mf_req),
    .flush     (flush),
    .accept    (accept),
    .busy      (busy),
    .stall_req (stall_req),
    .hi_out    (hi_out),
    .lo_out    (lo_out),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Architectural effect of one accepted command on HI/LO.
  task automatic model_apply(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      OP_DIV: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else begin q = sa / sb; r = sa % sb; m_hi = r[31:0]; m_lo = q[31:0]; end
      end
      OP_DIVU: begin
        if (b == 0) begin m_hi = a; m_lo = '1; end
        else begin m_hi = a % b; m_lo = a / b; end
      end
      OP_MTHI: m_hi = a;
      OP_MTLO: m_lo = a;
      default: ;
    endcase
  endtask

  // Called just after the accept edge; counts busy cycles and checks result.
  task automatic wait_done(input int exp_lat);
    int n = 0;
    while (busy === 1'b1 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("busy_cycles", 64'(n), 64'(exp_lat));
    check_eq("done_pulse", {63'd0, done}, 64'd1);
    check_eq("hi", {32'd0, hi_out}, {32'd0, m_hi});
    check_eq("lo", {32'd0, lo_out}, {32'd0, m_lo});
    @(posedge clk); #1;
    check_eq("done_clear", {63'd0, done}, 64'd0);
  endtask

  task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic exp_acc;
    exp_acc  = (o >= 3'd1) && (o <= 3'd6);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    #1;
    check_eq("accept", {63'd0, accept}, {63'd0, exp_acc});
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP;
    model_apply(o, a, b);
    if (o == OP_MULT || o == OP_MULTU) wait_done(MUL_C);
    else if (o == OP_DIV || o == OP_DIVU) wait_done(DIV_C + 1);
    else begin
      check_eq("busy_idle", {63'd0, busy}, 64'd0);
      check_eq("done_idle", {63'd0, done}, 64'd0);
      check_eq("hi_mt", {32'd0, hi_out}, {32'd0, m_hi});
      check_eq("lo_mt", {32'd0, lo_out}, {32'd0, m_lo});
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return W'($urandom_range(0, 20));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst_n = 1'b0; op_valid = 1'b0; op = OP_NOP; src_a = '0; src_b = '0;
    mf_req = 1'b0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hi", {32'd0, hi_out}, 64'd0);
    check_eq("rst_lo", {32'd0, lo_out}, 64'd0);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Moves, multiplies, divides with known answers.
    run_op(OP_MTHI, 32'h1234_5678, 32'h0);
    check_eq("mthi_const", {32'd0, hi_out}, 64'h1234_5678);
    run_op(OP_MTLO, 32'hCAFE_BABE, 32'h0);
    check_eq("mtlo_const", {32'd0, lo_out}, 64'hCAFE_BABE);
    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check_eq("mult_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3);
    check_eq("multu_const", {hi_out, lo_out}, 64'h0000_0002_FFFF_FFFA);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check_eq("div_const", {hi_out, lo_out}, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op(OP_DIVU, 32'd100, 32'd7);
    check_eq("divu_const", {hi_out, lo_out}, 64'h0000_0002_0000_000E);
    run_op(OP_DIV, 32'd5, 32'd0);
    check_eq("div0_const", {hi_out, lo_out}, 64'h0000_0005_FFFF_FFFF);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check_eq("divovf_const", {hi_out, lo_out}, 64'h0000_0000_8000_0000);
    run_op(3'd7, 32'h1111_1111, 32'h2222_2222);

    // MF stall during a divide, with a MULT held until the unit is idle.
    op_valid = 1'b1; op = OP_DIV; src_a = 32'hFFFF_FFEC; src_b = 32'd3;
    #1;
    check_eq("stall_div_acc", {63'd0, accept}, 64'd1);
    @(posedge clk); #1;
    model_apply(OP_DIV, 32'hFFFF_FFEC, 32'd3);
    op_valid = 1'b0; op = OP_NOP; mf_req = 1'b1;
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (n == 3) begin
        op_valid = 1'b1; op = OP_MULT; src_a = 32'd7; src_b = 32'hFFFF_FFFA;
      end
      #1;
      check_eq("stall_busy", {63'd0, stall_req}, 64'd1);
      if (n >= 3) check_eq("acc_blocked", {63'd0, accept}, 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check_eq("stall_div_cycles", 64'(n), 64'(DIV_C + 1));
    check_eq("stall_div_hi", {32'd0, hi_out}, {32'd0, m_hi});
    check_eq("stall_div_lo", {32'd0, lo_out}, {32'd0, m_lo});
    #1;
    check_eq("stall_released", {63'd0, stall_req}, 64'd0);
    check_eq("acc_after_idle", {63'd0, accept}, 64'd1);
    mf_req = 1'b0;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP;
    model_apply(OP_MULT, 32'd7, 32'hFFFF_FFFA);
    wait_done(MUL_C);

    // Flush mid-divide leaves preloaded HI/LO untouched.
    run_op(OP_MTHI, 32'h0000_AAAA, 32'h0);
    run_op(OP_MTLO, 32'h0000_5555, 32'h0);
    op_valid = 1'b1; op = OP_DIV; src_a = 32'd1000; src_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP;
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_busy", {63'd0, busy}, 64'd0);
    check_eq("flush_hilo", {hi_out, lo_out}, 64'h0000_AAAA_0000_5555);
    check_eq("flush_done", {63'd0, done}, 64'd0);
    @(posedge clk); #1;
    check_eq("flush_done2", {63'd0, done}, 64'd0);

    // Flush coincident with MTHI: not taken.
    op_valid = 1'b1; op = OP_MTHI; src_a = 32'hDEAD_BEEF; flush = 1'b1;
    #1;
    check_eq("flush_mthi_acc", {63'd0, accept}, 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP; flush = 1'b0;
    check_eq("flush_mthi_hi", {32'd0, hi_out}, 64'h0000_AAAA);

    // Flush on the final MUL edge suppresses the write.
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP;
    repeat (MUL_C - 1) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_eq("flush_last_hilo", {hi_out, lo_out}, 64'h0000_AAAA_0000_5555);
    check_eq("flush_last_done", {63'd0, done}, 64'd0);
    check_eq("flush_last_busy", {63'd0, busy}, 64'd0);

    // Asynchronous reset in the middle of a MULT.
    op_valid = 1'b1; op = OP_MULT; src_a = 32'd123; src_b = 32'd456;
    @(posedge clk); #1;
    op_valid = 1'b0; op = OP_NOP;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", {63'd0, busy}, 64'd0);
    check_eq("arst_hilo", {hi_out, lo_out}, 64'd0);
    m_hi = '0; m_lo = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_op(OP_MULT, 32'd123, 32'd456);

    // Random commands against the model.
    for (int i = 0; i < 60; i++) begin
      logic [2:0] ro;
      ro = 3'($urandom_range(0, 7));
      run_op(ro, pick(), pick());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
